// File: rtl/tdm_demux_1_4.sv
// Receive side of the 4:1 TDM link: rebuilds channels a..d from a serial
// sample stream, regenerating the slot select from the frame-sync marker.
module tdm_demux_1_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s0,
  output logic             s1,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] shadow_a, shadow_b, shadow_c;

  assign s0 = slot[0];
  assign s1 = slot[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= 2'd0;
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_c  <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow_a <= in_data;
              slot     <= 2'd1;
              state    <= LOCKED;
              locked   <= 1'b1;
            end
          end
          LOCKED: begin
            if (slot == 2'd0) begin
              if (frame_sync) begin
                shadow_a <= in_data;
                slot     <= 2'd1;
              end else begin
                // missing marker: drop sample and resynchronise from scratch
                sync_err <= 1'b1;
                slot     <= 2'd0;
                state    <= HUNT;
                locked   <= 1'b0;
              end
            end else if (frame_sync) begin
              // early marker restarts the frame; the partial one is abandoned
              sync_err <= 1'b1;
              shadow_a <= in_data;
              slot     <= 2'd1;
            end else begin
              case (slot)
                2'd1: begin
                  shadow_b <= in_data;
                  slot     <= 2'd2;
                end
                2'd2: begin
                  shadow_c <= in_data;
                  slot     <= 2'd3;
                end
                default: begin
                  a         <= shadow_a;
                  b         <= shadow_b;
                  c         <= shadow_c;
                  d         <= in_data;
                  out_valid <= 1'b1;
                  slot      <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state  <= HUNT;
            slot   <= 2'd0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
